// File: rtl/rgb_pwm_if.sv
// Handshake and pin bundle between the colour generators,
// the RGB PWM stage and the LED pins.
interface rgb_pwm_if #(
    parameter int W = 11
);
    logic         enable;
    logic         duty_valid;
    logic [W-1:0] R_value;
    logic [W-1:0] G_value;
    logic [W-1:0] B_value;
    logic         led_r;
    logic         led_g;
    logic         led_b;
    logic         period_start;
    logic         busy;

    modport master (
        output enable,
        output duty_valid,
        output R_value,
        output G_value,
        output B_value,
        input  led_r,
        input  led_g,
        input  led_b,
        input  period_start,
        input  busy
    );

    modport slave (
        input  enable,
        input  duty_valid,
        input  R_value,
        input  G_value,
        input  B_value,
        output led_r,
        output led_g,
        output led_b,
        output period_start,
        output busy
    );
endinterface

// File: rtl/rgb_pwm.sv
// Three-channel PWM with double-buffered duties that only
// change at period boundaries, so pins never glitch mid-period.
module rgb_pwm #(
    parameter int PWM_INTERVAL = 1250,
    parameter int W            = $clog2(PWM_INTERVAL),
    parameter int ACTIVE_LOW   = 1
) (
    input logic     clk,
    input logic     rst,
    rgb_pwm_if.slave bus
);
    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [W-1:0] LAST = W'(PWM_INTERVAL - 1);
    localparam logic [W-1:0] FULL = W'(PWM_INTERVAL);
    localparam logic         OFF  = (ACTIVE_LOW != 0);

    state_t       state;
    logic [W-1:0] count;
    logic [W-1:0] shadow_r, shadow_g, shadow_b;
    logic [W-1:0] active_r, active_g, active_b;
    logic         pending;
    logic         boundary;
    logic [W-1:0] src_r, src_g, src_b;

    function automatic logic [W-1:0] clamp(input logic [W-1:0] v);
        return (v > FULL) ? FULL : v;
    endfunction

    always_comb begin
        boundary = 1'b0;
        if (bus.enable) begin
            if (state == IDLE)
                boundary = 1'b1;
            else if (count == LAST)
                boundary = 1'b1;
        end
    end

    // A strobe landing on a boundary bypasses the shadow stage.
    assign src_r = bus.duty_valid ? bus.R_value : shadow_r;
    assign src_g = bus.duty_valid ? bus.G_value : shadow_g;
    assign src_b = bus.duty_valid ? bus.B_value : shadow_b;

    assign bus.busy = (state == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            count            <= '0;
            shadow_r         <= '0;
            shadow_g         <= '0;
            shadow_b         <= '0;
            active_r         <= '0;
            active_g         <= '0;
            active_b         <= '0;
            pending          <= 1'b0;
            bus.led_r        <= OFF;
            bus.led_g        <= OFF;
            bus.led_b        <= OFF;
            bus.period_start <= 1'b0;
        end else begin
            if (bus.duty_valid) begin
                shadow_r <= bus.R_value;
                shadow_g <= bus.G_value;
                shadow_b <= bus.B_value;
            end

            // Active already equals shadow when nothing is pending.
            if (boundary) begin
                if (pending || bus.duty_valid) begin
                    active_r <= clamp(src_r);
                    active_g <= clamp(src_g);
                    active_b <= clamp(src_b);
                end
                pending <= 1'b0;
            end else if (bus.duty_valid) begin
                pending <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    count <= '0;
                    if (bus.enable)
                        state <= RUN;
                end
                RUN: begin
                    if (count == LAST) begin
                        count <= '0;
                        if (!bus.enable)
                            state <= IDLE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase

            if (state == RUN) begin
                bus.led_r        <= OFF ^ (count < active_r);
                bus.led_g        <= OFF ^ (count < active_g);
                bus.led_b        <= OFF ^ (count < active_b);
                bus.period_start <= (count == '0);
            end else begin
                bus.led_r        <= OFF;
                bus.led_g        <= OFF;
                bus.led_b        <= OFF;
                bus.period_start <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rgb_pwm.sv
// Directed bench for rgb_pwm with a 10-cycle period and
// active-low pins.
module tb_rgb_pwm;
    localparam int PI = 10;
    localparam int W  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    rgb_pwm_if #(.W(W)) bus ();

    rgb_pwm #(
        .PWM_INTERVAL(PI),
        .W           (W),
        .ACTIVE_LOW  (1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] r;
        logic [W-1:0] g;
        logic [W-1:0] b;
        int           er;
        int           eg;
        int           eb;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_ps(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3 * PI; i++) begin
            if (bus.period_start) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk("period_start_timeout", int'(ok), 1);
    endtask

    // Sample i of a period shows the compare for count i.
    task automatic measure(
        input  int           s_idx,
        input  logic [W-1:0] r,
        input  logic [W-1:0] g,
        input  logic [W-1:0] b,
        input  int           d_idx,
        output int           nr,
        output int           ng,
        output int           nb
    );
        bit ok;
        int ps_bad;
        nr = 0;
        ng = 0;
        nb = 0;
        ps_bad = 0;
        wait_ps(ok);
        for (int i = 0; i < PI; i++) begin
            if (i > 0) begin
                step();
                bus.duty_valid = 1'b0;
            end
            if (bus.period_start != (i == 0))
                ps_bad++;
            if (!bus.led_r) nr++;
            if (!bus.led_g) ng++;
            if (!bus.led_b) nb++;
            if (i == s_idx) begin
                bus.duty_valid = 1'b1;
                bus.R_value    = r;
                bus.G_value    = g;
                bus.B_value    = b;
            end
            if (i == d_idx)
                bus.enable = 1'b0;
        end
        bus.duty_valid = 1'b0;
        chk("period_start_shape", ps_bad, 0);
    endtask

    initial begin
        int nr, ng, nb, bad, pulses;

        tbl[0] = '{r: 4'd3,  g: 4'd0,  b: 4'd10, er: 3,  eg: 0,  eb: 10};
        tbl[1] = '{r: 4'd15, g: 4'd1,  b: 4'd9,  er: 10, eg: 1,  eb: 9};
        tbl[2] = '{r: 4'd0,  g: 4'd10, b: 4'd11, er: 0,  eg: 10, eb: 10};
        tbl[3] = '{r: 4'd5,  g: 4'd5,  b: 4'd5,  er: 5,  eg: 5,  eb: 5};
        tbl[4] = '{r: 4'd1,  g: 4'd14, b: 4'd0,  er: 1,  eg: 10, eb: 0};

        bus.enable     = 1'b0;
        bus.duty_valid = 1'b0;
        bus.R_value    = '0;
        bus.G_value    = '0;
        bus.B_value    = '0;

        rst = 1'b1;
        step();
        step();
        chk("reset_leds", {bus.led_r, bus.led_g, bus.led_b}, 3'b111);
        chk("reset_busy", bus.busy, 0);
        chk("reset_ps", bus.period_start, 0);
        rst = 1'b0;
        step();

        bus.duty_valid = 1'b1;
        bus.R_value    = 4'd3;
        bus.G_value    = 4'd0;
        bus.B_value    = 4'd10;
        step();
        bus.duty_valid = 1'b0;
        chk("idle_busy", bus.busy, 0);
        chk("idle_leds", {bus.led_r, bus.led_g, bus.led_b}, 3'b111);

        bus.enable = 1'b1;
        step();
        chk("run_busy", bus.busy, 1);
        chk("run_first_leds", {bus.led_r, bus.led_g, bus.led_b}, 3'b111);
        chk("run_first_ps", bus.period_start, 0);
        step();
        chk("run_count0_ps", bus.period_start, 1);
        chk("run_count0_leds", {bus.led_r, bus.led_g, bus.led_b}, 3'b010);

        // Strobe R=7 while count is 4.
        measure(3, 4'd7, 4'd0, 4'd10, -1, nr, ng, nb);
        chk("mid_strobe_cur_r", nr, 3);
        chk("mid_strobe_cur_g", ng, 0);
        chk("mid_strobe_cur_b", nb, 10);
        measure(-1, '0, '0, '0, -1, nr, ng, nb);
        chk("mid_strobe_next_r", nr, 7);

        // Strobe G=6 on the wrap cycle.
        measure(8, 4'd7, 4'd6, 4'd10, -1, nr, ng, nb);
        chk("wrap_strobe_cur_g", ng, 0);
        measure(-1, '0, '0, '0, -1, nr, ng, nb);
        chk("wrap_strobe_next_g", ng, 6);
        chk("wrap_strobe_next_r", nr, 7);
        measure(-1, '0, '0, '0, -1, nr, ng, nb);
        chk("wrap_strobe_after_g", ng, 6);

        for (int k = 0; k < 5; k++) begin
            measure(0, tbl[k].r, tbl[k].g, tbl[k].b, -1, nr, ng, nb);
            measure(-1, '0, '0, '0, -1, nr, ng, nb);
            chk($sformatf("tbl%0d_r", k), nr, tbl[k].er);
            chk($sformatf("tbl%0d_g", k), ng, tbl[k].eg);
            chk($sformatf("tbl%0d_b", k), nb, tbl[k].eb);
        end

        // Drop enable at count 5: period still completes.
        measure(-1, '0, '0, '0, 4, nr, ng, nb);
        chk("stop_full_r", nr, 1);
        chk("stop_full_g", ng, 10);
        chk("stop_busy", bus.busy, 0);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if ({bus.led_r, bus.led_g, bus.led_b} != 3'b111) bad++;
            if (bus.period_start) bad++;
            if (bus.busy) bad++;
        end
        chk("stopped_quiet", bad, 0);

        bus.duty_valid = 1'b1;
        bus.R_value    = 4'd2;
        bus.G_value    = 4'd4;
        bus.B_value    = 4'd6;
        step();
        bus.duty_valid = 1'b0;
        bus.enable     = 1'b1;
        measure(-1, '0, '0, '0, -1, nr, ng, nb);
        chk("restart_r", nr, 2);
        chk("restart_g", ng, 4);
        chk("restart_b", nb, 6);

        // Async reset at count 6 with blue on.
        step();
        for (int i = 0; i < 5; i++) step();
        chk("pre_rst_led_b", bus.led_b, 0);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_leds", {bus.led_r, bus.led_g, bus.led_b}, 3'b111);
        chk("async_rst_busy", bus.busy, 0);
        #1 rst = 1'b0;
        bad = 0;
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if ({bus.led_r, bus.led_g, bus.led_b} != 3'b111) bad++;
            if (bus.period_start) pulses++;
        end
        chk("post_rst_all_off", bad, 0);
        chk("post_rst_pulses", pulses, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
